// File: rtl/bus_dma_master.sv
// Bus-initiator DMA engine: copies len words from src_addr to dst_addr, holding the bus for the whole block.
// Optional BUS_DMA_FILL_EN adds a pattern-fill mode (fill, fill_pattern) that skips the read phase.
module bus_dma_master #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
`ifdef BUS_DMA_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_pattern,
`endif
  output logic              busy,
  output logic              done,
  output logic              m_req,
  input  logic              m_grant,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] m_din
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_WR, S_DONE} state_e;

  state_e              state_q, state_d;
  state_e              resume_q, resume_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                fill_q, fill_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                req_q, req_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;

  // Next state, then outputs decoded from the next state so they leave a register.
  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    idx_d    = idx_q;
    len_d    = len_q;
    src_d    = src_q;
    dst_d    = dst_q;
    buf_d    = buf_q;
    fill_d   = fill_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    req_d    = 1'b0;
    wr_d     = 1'b0;
    addr_d   = '0;
    dout_d   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            src_d    = src_addr;
            dst_d    = dst_addr;
            len_d    = len;
            idx_d    = '0;
            resume_d = S_RD;
            fill_d   = 1'b0;
`ifdef BUS_DMA_FILL_EN
            fill_d = fill;
            if (fill) begin
              resume_d = S_WR;
              buf_d    = fill_pattern;
            end
`endif
            state_d = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (m_grant) state_d = resume_q;
      end
      S_RD: begin
        if (m_grant) begin
          buf_d   = m_din;
          state_d = S_WR;
        end else begin
          resume_d = S_RD;
          state_d  = S_REQ;
        end
      end
      S_WR: begin
        if (m_grant) begin
          if (idx_q == len_q - LEN_W'(1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = fill_q ? S_WR : S_RD;
          end
        end else begin
          resume_d = S_WR;
          state_d  = S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_REQ: begin
        busy_d = 1'b1;
        req_d  = 1'b1;
      end
      S_RD: begin
        busy_d = 1'b1;
        req_d  = 1'b1;
        addr_d = src_d + ADDR_W'(idx_d);
      end
      S_WR: begin
        busy_d = 1'b1;
        req_d  = 1'b1;
        wr_d   = 1'b1;
        addr_d = dst_d + ADDR_W'(idx_d);
        dout_d = buf_d;
      end
      S_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      resume_q <= S_RD;
      idx_q    <= '0;
      len_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      buf_q    <= '0;
      fill_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      buf_q    <= buf_d;
      fill_q   <= fill_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign m_req     = req_q;
  assign m_wr      = wr_q;
  assign m_address = addr_q;
  assign m_dout    = dout_q;

endmodule

// File: tb/tb_bus_dma_master.sv
// Self-checking bench for bus_dma_master: behavioural bus/memory model plus block-copy reference.
module tb_bus_dma_master;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic [LEN_W-1:0]  len;
  logic              busy, done, m_req, m_grant, m_wr;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_dout, m_din;
`ifdef BUS_DMA_FILL_EN
  logic              fill;
  logic [DATA_W-1:0] fill_pattern;
`endif

  logic [DATA_W-1:0]        mem [256];
  logic                     gnt_en;
  logic [ADDR_W+DATA_W-1:0] wr_log [$];
  int                       n_chk = 0;
  int                       n_err = 0;

  bus_dma_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
`ifdef BUS_DMA_FILL_EN
    .fill(fill), .fill_pattern(fill_pattern),
`endif
    .busy(busy), .done(done),
    .m_req(m_req), .m_grant(m_grant), .m_wr(m_wr),
    .m_address(m_address), .m_dout(m_dout), .m_din(m_din)
  );

  always #5 clk = ~clk;

  // Arbiter stand-in: grants whenever requested unless the bench withholds it.
  assign m_grant = m_req & gnt_en;
  assign m_din   = mem[m_address];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, set grant for the coming edge, and commit any granted write.
  task automatic bus_cycle(input bit g);
    @(negedge clk);
    gnt_en = g;
    if (!reset && m_req && g && m_wr) begin
      wr_log.push_back({m_address, m_dout});
      mem[m_address] = m_dout;
    end
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] s, input logic [7:0] d,
                          input logic [3:0] l, input bit f, input logic [31:0] pat,
                          input int off, input int k);
    logic [DATA_W-1:0]        em [256];
    logic [ADDR_W+DATA_W-1:0] exp_q [$];
    logic [7:0]               a, b;
    logic [DATA_W-1:0]        v;
    int per, exp_n, done_n, busy_cnt, req_cnt, bad, nw;
    em = mem;
    for (int i = 0; i < int'(l); i++) begin
      a = s + 8'(i);
      b = d + 8'(i);
      v = f ? pat : em[a];
      em[b] = v;
      exp_q.push_back({b, v});
    end
    per   = f ? 1 : 2;
    exp_n = (l == 0) ? 1 : 2 + per * int'(l) + k + ((k > 0 && off >= 2) ? 1 : 0);
    wr_log.delete();

    bus_cycle(1'b1);
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
`ifdef BUS_DMA_FILL_EN
    fill = f; fill_pattern = pat;
`endif
    done_n = 0; busy_cnt = 0; req_cnt = 0;
    for (int n = 1; n <= 300; n++) begin
      bus_cycle(!(n >= off && n < off + k));
      start = 1'b0;
      if (busy)  busy_cnt++;
      if (m_req) req_cnt++;
      if (done) begin
        done_n = n;
        break;
      end
    end
    check({tag, " done_cycle"}, 64'(done_n), 64'(exp_n));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_n));
    check({tag, " req_cycles"}, 64'(req_cnt), 64'((l == 0) ? 0 : exp_n - 1));
    bus_cycle(1'b1);
    check({tag, " busy_after"}, 64'(busy), 64'(0));
    check({tag, " done_after"}, 64'(done), 64'(0));
    check({tag, " write_count"}, 64'(wr_log.size()), 64'(exp_q.size()));
    nw = (wr_log.size() < exp_q.size()) ? wr_log.size() : exp_q.size();
    for (int i = 0; i < nw; i++)
      check($sformatf("%s write%0d", tag, i), 64'(wr_log[i]), 64'(exp_q[i]));
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== em[i]) bad++;
    check({tag, " mem_mismatches"}, 64'(bad), 64'(0));
  endtask

  initial begin
    int l, per, off, k;
    reset = 1'b1; start = 1'b0; gnt_en = 1'b1;
    src_addr = '0; dst_addr = '0; len = '0;
`ifdef BUS_DMA_FILL_EN
    fill = 1'b0; fill_pattern = '0;
`endif
    for (int i = 0; i < 256; i++)
      mem[i] = (i < 32) ? 32'h1111_0000 + 32'(i) : $urandom;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst busy", 64'(busy), 64'(0));
    check("rst done", 64'(done), 64'(0));
    check("rst m_req", 64'(m_req), 64'(0));
    check("rst m_wr", 64'(m_wr), 64'(0));
    check("rst m_address", 64'(m_address), 64'(0));
    check("rst m_dout", 64'(m_dout), 64'(0));

    run_xfer("copy", 8'h01, 8'h21, 4'd4, 1'b0, 32'h0, 0, 0);
    run_xfer("len0", 8'h03, 8'h23, 4'd0, 1'b0, 32'h0, 0, 0);
    run_xfer("gntloss", 8'h01, 8'h21, 4'd4, 1'b0, 32'h0, 5, 3);
    run_xfer("wrap", 8'hFE, 8'h1E, 4'd3, 1'b0, 32'h0, 0, 0);

    // Abort during the second read, then confirm a clean restart.
    bus_cycle(1'b1);
    src_addr = 8'h05; dst_addr = 8'h25; len = 4'd4; start = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      bus_cycle(1'b1);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("abort m_req", 64'(m_req), 64'(0));
    check("abort m_wr", 64'(m_wr), 64'(0));
    check("abort m_address", 64'(m_address), 64'(0));
    check("abort m_dout", 64'(m_dout), 64'(0));
    check("abort busy", 64'(busy), 64'(0));
    check("abort done", 64'(done), 64'(0));
    for (int n = 0; n < 3; n++) begin
      bus_cycle(1'b1);
      check("abort no_done", 64'(done), 64'(0));
    end
    reset = 1'b0;
    run_xfer("restart", 8'h05, 8'h25, 4'd4, 1'b0, 32'h0, 0, 0);

    for (int t = 0; t < 10; t++) begin
      l   = int'($urandom_range(1, 15));
      per = 2;
      off = int'($urandom_range(1, 1 + per * l));
      k   = int'($urandom_range(0, 3));
      run_xfer($sformatf("rand%0d", t), 8'($urandom), 8'($urandom), 4'(l), 1'b0, 32'h0, off, k);
    end

`ifdef BUS_DMA_FILL_EN
    run_xfer("fill", 8'h00, 8'h00, 4'd5, 1'b1, 32'hDEADBEEF, 0, 0);
    run_xfer("fill_drop", 8'h10, 8'h30, 4'd6, 1'b1, $urandom, 4, 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
